rv32i_fetch_unit: RTL

Instruction-fetch initiator for the multicycle RV32I core. It owns the program counter and drives the read port of the instruction memory using that memory's three-cycle read handshake. It buffers fetched words and presents them to decode over a valid/ready interface, and it accepts PC redirects from execute (branches, jumps and traps). It sits between the instruction memory and the decode stage.

---
 rtl/rv32i_core_pkg.sv | 22 ++
 rtl/rv32i_fetch_unit_if.sv | 24 ++
 rtl/rv32i_fetch_buffer.sv | 67 ++++++
 rtl/rv32i_fetch_unit.sv | 95 +++++++++
 4 files changed

// File: rtl/rv32i_core_pkg.sv
// Shared types and constants for the RV32I core front end.
package rv32i_core_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_ALIGN_MASK = 32'h3;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr & INSTR_ALIGN_MASK) == 32'h0;
  endfunction

endpackage

// File: rtl/rv32i_fetch_unit_if.sv
// Fetch unit bus: instruction-memory read port, decode valid/ready and redirect.
interface rv32i_fetch_unit_if;
  logic        o_imem_rd_en;
  logic [31:0] o_imem_rd_addr;
  logic [31:0] i_imem_rd_data;
  logic        i_imem_rd_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_fetch_fault;

  modport master (
    output o_imem_rd_en, o_imem_rd_addr, o_instr, o_instr_pc, o_instr_valid, o_fetch_fault,
    input  i_imem_rd_data, i_imem_rd_valid, i_instr_ready, i_redirect_valid, i_redirect_pc
  );

  modport slave (
    input  o_imem_rd_en, o_imem_rd_addr, o_instr, o_instr_pc, o_instr_valid, o_fetch_fault,
    output i_imem_rd_data, i_imem_rd_valid, i_instr_ready, i_redirect_valid, i_redirect_pc
  );
endinterface

// File: rtl/rv32i_fetch_buffer.sv
// Small register FIFO (depth 1 or 2) holding fetched {instr, pc} entries; head at index 0.
module rv32i_fetch_buffer
  import rv32i_core_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  fetch_entry_t                 data_i,
  output fetch_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     entries_q [DEPTH];
  fetch_entry_t     entries_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_eff;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign pop_eff = pop_i && !empty_o;
  assign head_o  = entries_q[0];
  assign count_o = count_q;

  // Pop shifts toward the head first, so a push in the same cycle lands behind the survivors.
  always_comb begin
    int  widx;
    logic push_ok;
    entries_d = entries_q;
    count_d   = count_q;
    widx      = int'(count_q);
    push_ok   = 1'b0;
    if (flush_i) begin
      count_d = '0;
    end else begin
      if (pop_eff) begin
        for (int i = 0; i < DEPTH - 1; i++) entries_d[i] = entries_q[i+1];
        widx = widx - 1;
      end
      push_ok = push_i && (widx < DEPTH);
      if (push_ok) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == widx) entries_d[i] = data_i;
        end
      end
      count_d = CNT_W'(widx + (push_ok ? 1 : 0));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch: owns the PC, runs the 3-cycle imem read, buffers words for decode.
// Build option: RV32I_FETCH_PREFETCH_EN selects a 2-entry buffer (default 1 entry).
module rv32i_fetch_unit
  import rv32i_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  rv32i_fetch_unit_if.master bus
);

  // state | meaning
  // FETCH | imem read in progress at pc_q
  // HOLD  | buffer full, waiting for decode to pop
  // FLUSH | one idle cycle after a redirect so the memory read FSM restarts
  // FAULT | misaligned redirect target, fetch halted until an aligned redirect

`ifdef RV32I_FETCH_PREFETCH_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             redirect, rd_hit, push, pop, room_after_push;
  logic [CNT_W-1:0] buf_count;
  logic             buf_full, buf_empty;
  fetch_entry_t     head, new_entry;

  assign redirect  = bus.i_redirect_valid;
  assign rd_hit    = (state_q == FETCH) && bus.i_imem_rd_valid;
  assign pop       = bus.o_instr_valid && bus.i_instr_ready;
  assign push      = rd_hit && !redirect;
  assign new_entry = '{instr: bus.i_imem_rd_data, pc: pc_q};
  assign room_after_push = (int'(buf_count) + 1 - (pop ? 1 : 0)) < BUF_DEPTH;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect) begin
      pc_d    = bus.i_redirect_pc;
      state_d = is_aligned(bus.i_redirect_pc) ? FLUSH : FAULT;
    end else begin
      case (state_q)
        FETCH: begin
          if (rd_hit) begin
            pc_d = pc_q + 32'd4;
            if (!room_after_push) state_d = HOLD;
          end
        end
        HOLD:    if (pop || !buf_full) state_d = FETCH;
        FLUSH:   state_d = FETCH;
        FAULT:   state_d = FAULT;
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    bus.o_imem_rd_en  = (state_q == FETCH) && !i_rst;
    bus.o_fetch_fault = (state_q == FAULT);
  end

  assign bus.o_imem_rd_addr = pc_q;
  assign bus.o_instr        = head.instr;
  assign bus.o_instr_pc     = head.pc;
  assign bus.o_instr_valid  = !buf_empty;

  rv32i_fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buffer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_i  (new_entry),
    .head_o  (head),
    .count_o (buf_count),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

endmodule
